// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic valid/ready pipeline register with flush and stall counter
//
// Purpose: one pipeline stage boundary. It carries a DATA_W payload and a
// CTRL_W control field. out_ctrl reads zero whenever the stage holds a bubble.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_ctrl       upstream beat handshake
//   out_valid/out_ready/out_data/out_ctrl   downstream beat handshake
//   flush                             kills every held beat on the next edge
//   cnt_clr                           clears stall_cnt on the next edge
//   stall_cnt                         saturating count of out_valid & !out_ready edges
//
// Build option: define PIPE_SKID_EN to add a one-entry skid buffer. With the
// buffer, in_ready is a registered signal and has no combinational path
// from out_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic accept;
    logic stall;

    assign accept = in_valid & in_ready;
    assign stall  = out_valid & ~out_ready;

    // The clear beats the increment. A flushed stall edge does not count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall && !flush && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // The stage can always take one more beat while the skid slot is free.
    assign in_ready = ~skid_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ctrl   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
        end else if (!out_valid || out_ready) begin
            // The main slot is free or draining. The older skid beat goes first.
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_ctrl   <= skid_ctrl;
                skid_valid <= 1'b0;
                skid_ctrl  <= '0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_ctrl  <= in_ctrl;
            end else begin
                out_valid <= 1'b0;
                out_ctrl  <= '0;
            end
        end else if (accept) begin
            // The main slot is stalled. Park the incoming beat in the skid slot.
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_ctrl  <= in_ctrl;
        end
    end
`else
    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_ctrl  <= in_ctrl;
        end else if (out_ready) begin
            // Drain with no replacement beat: payload stays, control reads as a bubble.
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;

    localparam int DW      = 64;
    localparam int CW      = 8;
    localparam int NW      = 4;
    localparam int CNT_TOP = 15;
`ifdef PIPE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          flush;
    logic          cnt_clr;
    logic [NW-1:0] stall_cnt;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of capacity DEPTH. The head is what out_* shows.
    logic [DW-1:0] m_qd[$];
    logic [CW-1:0] m_qc[$];
    logic [DW-1:0] m_last;
    int            m_cnt;
    bit            m_rdy;

    function automatic bit m_in_ready();
        if (DEPTH == 2) return m_qd.size() < 2;
        return (m_qd.size() == 0) || out_ready;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_qd.delete();
            m_qc.delete();
            m_last = '0;
            m_cnt  = 0;
        end else begin
            m_rdy = m_in_ready();
            if (cnt_clr) m_cnt = 0;
            else if (m_qd.size() > 0 && !out_ready && !flush && m_cnt < CNT_TOP) m_cnt++;
            if (flush) begin
                m_qd.delete();
                m_qc.delete();
            end else begin
                if (m_qd.size() > 0 && out_ready) begin
                    void'(m_qd.pop_front());
                    void'(m_qc.pop_front());
                end
                if (in_valid && m_rdy) begin
                    m_qd.push_back(in_data);
                    m_qc.push_back(in_ctrl);
                end
            end
            if (m_qd.size() > 0) m_last = m_qd[0];
        end
    end

    always @(negedge clk) begin
        if (cmp_en && reset_n) begin
            chk("cmp_out_valid", 64'(out_valid), 64'(m_qd.size() > 0));
            chk("cmp_out_data", out_data, (m_qd.size() > 0) ? m_qd[0] : m_last);
            chk("cmp_out_ctrl", 64'(out_ctrl), (m_qd.size() > 0) ? 64'(m_qc[0]) : 64'h0);
            chk("cmp_in_ready", 64'(in_ready), 64'(m_in_ready()));
            chk("cmp_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
            chk("cmp_ctrl_invariant", 64'(out_ctrl != '0 && !out_valid), 64'h0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        cyc(); cyc();
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_out_data", out_data, 64'h0);
        chk("reset_out_ctrl", 64'(out_ctrl), 64'h0);
        chk("reset_in_ready", 64'(in_ready), 64'h1);
        chk("reset_stall_cnt", 64'(stall_cnt), 64'h0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // Streaming data 1..8 with one cycle of lag and no gaps.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 64'(i); in_ctrl = 8'(i);
            cyc();
            chk("stream_data", out_data, 64'(i));
            chk("stream_valid", 64'(out_valid), 64'h1);
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_drain_valid", 64'(out_valid), 64'h0);
        chk("stream_drain_data_held", out_data, 64'h8);

        // Backpressure: 0xA5 is held for 5 stalled edges while 0xA6 waits.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA5; in_ctrl = 8'h3;
        cyc();
        in_data = 64'hA6; in_ctrl = 8'h4;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_hold_data", out_data, 64'hA5);
            chk("bp_hold_ctrl", 64'(out_ctrl), 64'h3);
            chk("bp_in_ready", 64'(in_ready), 64'h0);
        end
        chk("bp_stall_cnt", 64'(stall_cnt), 64'h5);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
`ifdef PIPE_SKID_EN
        chk("bp_skid_second_data", out_data, 64'hA6);
        chk("bp_skid_second_valid", 64'(out_valid), 64'h1);
        cyc();
`endif
        chk("bp_release_empty", 64'(out_valid), 64'h0);
        chk("bp_release_cnt", 64'(stall_cnt), 64'h5);

        // Flush while a beat (0x77) handshakes in the same cycle.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h10; in_ctrl = 8'h1;
        cyc();
        flush = 1'b1; out_ready = 1'b1; in_data = 64'h77; in_ctrl = 8'h7;
        cyc();
        chk("flush_valid", 64'(out_valid), 64'h0);
        chk("flush_ctrl", 64'(out_ctrl), 64'h0);
        chk("flush_data_held", out_data, 64'h10);
        flush = 1'b0; in_valid = 1'b0;
        cyc();
        chk("flush_no_77", out_data, 64'h10);

        // Flush with both the main entry and the skid entry occupied.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hB1; in_ctrl = 8'h11;
        cyc();
        in_data = 64'hB2; in_ctrl = 8'h12;
        cyc();
        in_valid = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_full_valid", 64'(out_valid), 64'h0);
        chk("flush_full_in_ready", 64'(in_ready), 64'h1);
        chk("flush_full_cnt", 64'(stall_cnt), 64'h6);
        out_ready = 1'b1;
        cyc();
        chk("flush_full_stays_empty", 64'(out_valid), 64'h0);

        // Counter saturation and clear-during-stall priority.
        cnt_clr = 1'b1;
        cyc();
        chk("cnt_clear", 64'(stall_cnt), 64'h0);
        cnt_clr = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h20; in_ctrl = 8'h2;
        cyc();
        in_valid = 1'b0;
        repeat (20) cyc();
        chk("cnt_saturate", 64'(stall_cnt), 64'hF);
        cnt_clr = 1'b1;
        cyc();
        chk("cnt_clr_in_stall", 64'(stall_cnt), 64'h0);
        cnt_clr = 1'b0;
        cyc();
        chk("cnt_restart", 64'(stall_cnt), 64'h1);
        out_ready = 1'b1;
        cyc();

        // A bubble input with nonzero control must never load.
        in_valid = 1'b0; in_ctrl = 8'hFF; in_data = 64'h99;
        for (int k = 0; k < 4; k++) begin
            out_ready = (k < 2);
            cyc();
            chk("bubble_ctrl", 64'(out_ctrl), 64'h0);
            chk("bubble_valid", 64'(out_valid), 64'h0);
            chk("bubble_data_held", out_data, 64'h20);
        end

        // Reset asserted mid-cycle while the stage holds a beat.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD; in_ctrl = 8'h5;
        cyc();
        chk("pre_reset_valid", 64'(out_valid), 64'h1);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'h0);
        chk("async_reset_ctrl", 64'(out_ctrl), 64'h0);
        chk("async_reset_cnt", 64'(stall_cnt), 64'h0);
        chk("async_reset_in_ready", 64'(in_ready), 64'h1);
        chk("async_reset_data", out_data, 64'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        cyc();
        chk("post_reset_valid", 64'(out_valid), 64'h0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
